// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG decoder output path: pixel packing modes and
// fixed-point YCbCr->RGB coefficient derivation.
package aq_djpeg_pkg;

  typedef enum logic [1:0] {
    CSC_RGB888 = 2'd0,
    CSC_RGB565 = 2'd1,
    CSC_Y8     = 2'd2,
    CSC_BGR888 = 2'd3
  } cscMode_e;

  // BT.601 full-range coefficients in parts per million (magnitudes; signs applied in the datapath)
  localparam longint CR_R_PPM = 1402000;
  localparam longint CB_G_PPM = 344136;
  localparam longint CR_G_PPM = 714136;
  localparam longint CB_B_PPM = 1772000;

  // round(ppm/1e6 * 2^frac), halves rounded up
  function automatic int coefFix(input longint ppm, input int frac);
    longint scaled;
    scaled  = ppm * (longint'(1) << frac);
    coefFix = int'((2 * scaled + 64'sd1000000) / 64'sd2000000);
  endfunction

  localparam int COEF_FRAC_DEF = 10;
  localparam int CR_R_DEF = coefFix(CR_R_PPM, COEF_FRAC_DEF);
  localparam int CB_G_DEF = coefFix(CB_G_PPM, COEF_FRAC_DEF);
  localparam int CR_G_DEF = coefFix(CR_G_PPM, COEF_FRAC_DEF);
  localparam int CB_B_DEF = coefFix(CB_B_PPM, COEF_FRAC_DEF);

endpackage

// File: rtl/aq_djpeg_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output and synchronous flush.
module aq_djpeg_sync_fifo
  import aq_djpeg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wrData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdData,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic             full, doPop;

  assign empty  = (level == '0);
  assign full   = (level == LVL_W'(DEPTH));
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrData;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (push)  wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({push, doPop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/aq_djpeg_csc_stream.sv
// YCbCr->RGB converter: 3-stage never-stalling datapath feeding a credit-guarded
// output FIFO with per-pixel packing mode, coordinates and frame-last marker.
module aq_djpeg_csc_stream
  import aq_djpeg_pkg::*;
#(
  parameter int IN_W       = 9,
  parameter int COEF_FRAC  = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int COORD_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ProcessInit,
  input  logic                        InEnable,
  output logic                        InReady,
  input  logic [2:0]                  InComp,
  input  logic [1:0]                  InMode,
  input  logic [IN_W-1:0]             InY,
  input  logic [IN_W-1:0]             InCb,
  input  logic [IN_W-1:0]             InCr,
  input  logic [COORD_W-1:0]          InPixelX,
  input  logic [COORD_W-1:0]          InPixelY,
  input  logic                        InLast,
  input  logic                        OutReady,
  output logic                        OutEnable,
  output logic [23:0]                 OutData,
  output logic [COORD_W-1:0]          OutPixelX,
  output logic [COORD_W-1:0]          OutPixelY,
  output logic                        OutLast,
  output logic [$clog2(FIFO_DEPTH):0] FifoLevel
);

  localparam int COEF_W  = COEF_FRAC + 2;
  localparam int PROD_W  = IN_W + COEF_W;
  localparam int ACC_W   = PROD_W + 3;
  localparam int RES_W   = ACC_W - COEF_FRAC;
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = 24 + 2 * COORD_W + 1;

  localparam logic signed [COEF_W-1:0] K_CR_R = COEF_W'(coefFix(CR_R_PPM, COEF_FRAC));
  localparam logic signed [COEF_W-1:0] K_CB_G = COEF_W'(coefFix(CB_G_PPM, COEF_FRAC));
  localparam logic signed [COEF_W-1:0] K_CR_G = COEF_W'(coefFix(CR_G_PPM, COEF_FRAC));
  localparam logic signed [COEF_W-1:0] K_CB_B = COEF_W'(coefFix(CB_B_PPM, COEF_FRAC));
  // +128 output offset plus half-LSB for round-half-up before the arithmetic shift
  localparam logic signed [ACC_W-1:0] BIAS =
    ACC_W'((longint'(128) << COEF_FRAC) + (longint'(1) << (COEF_FRAC - 1)));

  function automatic logic [7:0] clamp8(input logic signed [RES_W-1:0] v);
    if (v[RES_W-1])            clamp8 = 8'h00;
    else if (v > RES_W'(255))  clamp8 = 8'hFF;
    else                       clamp8 = v[7:0];
  endfunction

  function automatic logic [23:0] pack(input cscMode_e m, input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b, input logic [7:0] y8);
    case (m)
      CSC_RGB565: pack = {8'h00, r[7:3], g[7:2], b[7:3]};
      CSC_Y8:     pack = {16'h0000, y8};
      CSC_BGR888: pack = {b, g, r};
      default:    pack = {r, g, b};
    endcase
  endfunction

  logic signed [IN_W-1:0] yIn, cbIn, crIn;
  logic                   gray, accept;
  logic                   vld_p1, vld_p2, vld_p3;
  logic [LVL_W-1:0]       inFlight;

  assign gray = (InComp == 3'd1);
  assign yIn  = $signed(InY);
  assign cbIn = gray ? '0 : $signed(InCb);
  assign crIn = gray ? '0 : $signed(InCr);

  assign inFlight = LVL_W'(vld_p1) + LVL_W'(vld_p2) + LVL_W'(vld_p3);
  assign InReady  = !ProcessInit && ((FifoLevel + inFlight) < LVL_W'(FIFO_DEPTH));
  assign accept   = InEnable && InReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (ProcessInit) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // S1: coefficient multiplies
  logic signed [IN_W-1:0]   y_p1;
  logic signed [PROD_W-1:0] crR_p1, cbG_p1, crG_p1, cbB_p1;
  cscMode_e                 mode_p1;
  logic [COORD_W-1:0]       pixX_p1, pixY_p1;
  logic                     last_p1;

  always_ff @(posedge clk) begin
    if (accept) begin
      y_p1    <= yIn;
      crR_p1  <= PROD_W'(crIn) * PROD_W'(K_CR_R);
      cbG_p1  <= PROD_W'(cbIn) * PROD_W'(K_CB_G);
      crG_p1  <= PROD_W'(crIn) * PROD_W'(K_CR_G);
      cbB_p1  <= PROD_W'(cbIn) * PROD_W'(K_CB_B);
      mode_p1 <= cscMode_e'(InMode);
      pixX_p1 <= InPixelX;
      pixY_p1 <= InPixelY;
      last_p1 <= InLast;
    end
  end

  // S2: sum, round, scale back to integer
  logic signed [ACC_W-1:0] yScaled, accR, accG, accB;
  logic signed [RES_W-1:0] r_p2, g_p2, b_p2, y8_p2;
  cscMode_e                mode_p2;
  logic [COORD_W-1:0]      pixX_p2, pixY_p2;
  logic                    last_p2;

  always_comb begin
    yScaled = ACC_W'(y_p1) <<< COEF_FRAC;
    accR    = yScaled + ACC_W'(crR_p1) + BIAS;
    accG    = yScaled - ACC_W'(cbG_p1) - ACC_W'(crG_p1) + BIAS;
    accB    = yScaled + ACC_W'(cbB_p1) + BIAS;
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      r_p2    <= RES_W'(accR >>> COEF_FRAC);
      g_p2    <= RES_W'(accG >>> COEF_FRAC);
      b_p2    <= RES_W'(accB >>> COEF_FRAC);
      y8_p2   <= RES_W'(y_p1) + RES_W'(128);
      mode_p2 <= mode_p1;
      pixX_p2 <= pixX_p1;
      pixY_p2 <= pixY_p1;
      last_p2 <= last_p1;
    end
  end

  // S3: clamp and pack into a FIFO entry
  logic [ENTRY_W-1:0] entry_p3;

  always_ff @(posedge clk) begin
    if (vld_p2) begin
      entry_p3 <= {last_p2, pixY_p2, pixX_p2,
                   pack(mode_p2, clamp8(r_p2), clamp8(g_p2), clamp8(b_p2), clamp8(y8_p2))};
    end
  end

  logic [ENTRY_W-1:0] headEntry;
  logic               fifoEmpty;

  aq_djpeg_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (ProcessInit),
    .push   (vld_p3),
    .wrData (entry_p3),
    .pop    (OutReady),
    .rdData (headEntry),
    .empty  (fifoEmpty),
    .level  (FifoLevel)
  );

  assign OutEnable = !fifoEmpty;
  assign {OutLast, OutPixelY, OutPixelX, OutData} = fifoEmpty ? '0 : headEntry;

endmodule

// File: tb/tb_aq_djpeg_csc_stream.sv
// Directed bench for aq_djpeg_csc_stream: known colour vectors, latency,
// backpressure/credit, flush, mid-stream reset and a randomised ordering run.
module tb_aq_djpeg_csc_stream;

  logic        clk = 1'b0;
  logic        rst, ProcessInit, InEnable, InReady, InLast, OutReady, OutEnable, OutLast;
  logic [2:0]  InComp;
  logic [1:0]  InMode;
  logic [8:0]  InY, InCb, InCr;
  logic [15:0] InPixelX, InPixelY, OutPixelX, OutPixelY;
  logic [23:0] OutData;
  logic [3:0]  FifoLevel;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  aq_djpeg_csc_stream #(
    .IN_W(9), .COEF_FRAC(10), .FIFO_DEPTH(8), .COORD_W(16)
  ) dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit),
    .InEnable(InEnable), .InReady(InReady), .InComp(InComp), .InMode(InMode),
    .InY(InY), .InCb(InCb), .InCr(InCr),
    .InPixelX(InPixelX), .InPixelY(InPixelY), .InLast(InLast),
    .OutReady(OutReady), .OutEnable(OutEnable), .OutData(OutData),
    .OutPixelX(OutPixelX), .OutPixelY(OutPixelY), .OutLast(OutLast),
    .FifoLevel(FifoLevel)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int y, input int cb, input int cr, input int comp, input int mode,
                       input int x, input int py, input bit last);
    InY      = y[8:0];
    InCb     = cb[8:0];
    InCr     = cr[8:0];
    InComp   = comp[2:0];
    InMode   = mode[1:0];
    InPixelX = x[15:0];
    InPixelY = py[15:0];
    InLast   = last;
  endtask

  task automatic sendPix(input int y, input int cb, input int cr, input int comp, input int mode);
    drive(y, cb, cr, comp, mode, 7, 9, 1'b0);
    InEnable = 1'b1;
    step();
    InEnable = 1'b0;
  endtask

  // Wait (bounded) for a head entry, compare it, then pop it
  task automatic expectOut(input string tag, input logic [23:0] exp);
    for (int i = 0; i < 10 && !OutEnable; i++) step();
    chk({tag, "_en"}, 64'(OutEnable), 64'd1);
    chk(tag, 64'(OutData), 64'(exp));
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
  endtask

  // Grayscale pixel i: Cb/Cr deliberately nonzero to show they are ignored
  task automatic setGray(input int i);
    drive(i, 55, -30, 1, 0, i, 100 + i, i == 19);
  endtask

  function automatic logic [7:0] grayExp(input int ys);
    if (ys < -128)     grayExp = 8'h00;
    else if (ys > 127) grayExp = 8'hFF;
    else               grayExp = 8'(ys + 128);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx, k, firstCyc, lastCyc, sent, got, mode;
    bit          acc, pop, lst;
    logic [23:0] d, e;
    logic [15:0] ox, oy;
    logic [8:0]  ry;
    logic [23:0] q[$];

    rst = 1'b1; ProcessInit = 1'b0; InEnable = 1'b0; OutReady = 1'b0;
    drive(0, 0, 0, 3, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inready", 64'(InReady), 64'd1);
    chk("rst_outen",   64'(OutEnable), 64'd0);
    chk("rst_data",    64'(OutData), 64'd0);
    chk("rst_level",   64'(FifoLevel), 64'd0);
    rst = 1'b0;
    step();

    // Mid-grey pixel and 3-edge latency
    drive(0, 0, 0, 3, 0, 1, 2, 1'b0);
    InEnable = 1'b1;
    step();
    InEnable = 1'b0;
    chk("t1_lat0", 64'(OutEnable), 64'd0);
    step(); chk("t1_lat1", 64'(OutEnable), 64'd0);
    step(); chk("t1_lat2", 64'(OutEnable), 64'd0);
    step(); chk("t1_lat3", 64'(OutEnable), 64'd1);
    chk("t1_data",  64'(OutData), 64'h808080);
    chk("t1_x",     64'(OutPixelX), 64'd1);
    chk("t1_y",     64'(OutPixelY), 64'd2);
    chk("t1_level", 64'(FifoLevel), 64'd1);
    OutReady = 1'b1; step(); OutReady = 1'b0;
    chk("t1_drained", 64'(OutEnable), 64'd0);

    // Saturation, packing modes, low clamp, grayscale
    sendPix(127, 0, 127, 3, 0);     expectOut("t2_rgb888", 24'hFFA4FF);
    sendPix(127, 0, 127, 3, 1);     expectOut("t2_rgb565", 24'h00FD3F);
    sendPix(127, 0, 127, 3, 2);     expectOut("t2_y8",     24'h0000FF);
    sendPix(-100, 0, 50, 3, 0);     expectOut("t2_mix888", 24'h62001C);
    sendPix(-100, 0, 50, 3, 3);     expectOut("t2_mixbgr", 24'h1C0062);
    sendPix(-100, 0, 50, 3, 2);     expectOut("t2_mixy8",  24'h00001C);
    sendPix(-256, -256, -256, 3, 0); expectOut("t3_low",   24'h008F00);
    sendPix(50, 100, 0, 1, 0);      expectOut("t3_gray",   24'hB2B2B2);

    // Backpressure: only FIFO_DEPTH pixels may be accepted
    OutReady = 1'b0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      setGray(idx);
      InEnable = (idx < 20);
      acc = InEnable && InReady;
      step();
      if (acc) idx++;
    end
    chk("t4_accepted", 64'(idx), 64'd8);
    chk("t4_inready",  64'(InReady), 64'd0);
    chk("t4_level",    64'(FifoLevel), 64'd8);
    OutReady = 1'b1;
    k = 0; firstCyc = 0; lastCyc = 0;
    for (int c = 0; c < 100 && k < 20; c++) begin
      setGray(idx);
      InEnable = (idx < 20);
      acc = InEnable && InReady;
      pop = OutEnable;
      d = OutData; ox = OutPixelX; oy = OutPixelY; lst = OutLast;
      step();
      if (acc) idx++;
      if (pop) begin
        e = {3{8'(128 + k)}};
        chk("t4_data", 64'(d), 64'(e));
        chk("t4_x",    64'(ox), 64'(k));
        chk("t4_y",    64'(oy), 64'(100 + k));
        chk("t4_last", 64'(lst), 64'(k == 19));
        if (k == 0) firstCyc = c;
        lastCyc = c;
        k++;
      end
    end
    InEnable = 1'b0; OutReady = 1'b0;
    chk("t4_count", 64'(k), 64'd20);
    chk("t4_span",  64'(lastCyc - firstCyc), 64'd19);

    // Flush with 5 queued and 3 in flight
    for (int i = 0; i < 8; i++) begin
      setGray(40 + i);
      InEnable = 1'b1;
      step();
    end
    chk("t5_level5", 64'(FifoLevel), 64'd5);
    ProcessInit = 1'b1;
    #1;
    chk("t5_pi_ready", 64'(InReady), 64'd0);
    step();
    ProcessInit = 1'b0; InEnable = 1'b0;
    chk("t5_level0", 64'(FifoLevel), 64'd0);
    chk("t5_outen0", 64'(OutEnable), 64'd0);
    repeat (5) step();
    chk("t5_level_later", 64'(FifoLevel), 64'd0);
    chk("t5_outen_later", 64'(OutEnable), 64'd0);
    sendPix(77, 0, 0, 1, 0);
    expectOut("t5_fresh", 24'hCDCDCD);
    chk("t5_empty_after", 64'(FifoLevel), 64'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) begin
      setGray(i);
      InEnable = 1'b1;
      step();
    end
    InEnable = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("t7_level",   64'(FifoLevel), 64'd0);
    chk("t7_outen",   64'(OutEnable), 64'd0);
    chk("t7_data",    64'(OutData), 64'd0);
    chk("t7_inready", 64'(InReady), 64'd1);
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("t7_no_partial", 64'(OutEnable), 64'd0);

    // Randomised handshakes against an in-order scoreboard
    sent = 0; got = 0;
    for (int c = 0; c < 20000 && got < 2000; c++) begin
      ry   = 9'($urandom_range(0, 511));
      mode = ($urandom_range(0, 2) == 0) ? 2 : 0;
      drive(int'($signed(ry)), 80, -80, 1, mode, c, sent, 1'b0);
      InEnable = (sent < 2000) && ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 2) != 0);
      acc = InEnable && InReady;
      pop = OutEnable && OutReady;
      d = OutData;
      e = (mode == 2) ? {16'h0000, grayExp(int'($signed(ry)))} : {3{grayExp(int'($signed(ry)))}};
      step();
      if (acc) begin
        q.push_back(e);
        sent++;
      end
      if (pop) begin
        chk("rnd_nonempty", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) chk("rnd_data", 64'(d), 64'(q.pop_front()));
        got++;
      end
    end
    InEnable = 1'b0; OutReady = 1'b0;
    chk("rnd_count", 64'(got), 64'd2000);
    chk("rnd_left",  64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
